// File: rtl/rv32i_pkg.sv
// Shared types, opcode constants and lane helpers for the rv32i memory-access stage.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    WIDTH_B = 2'd0,
    WIDTH_H = 2'd1,
    WIDTH_W = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_IO_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] lane;
    width_e     width;
    logic       is_unsigned;
  } ld_info_t;

  function automatic logic [3:0] byte_enable(input width_e w, input logic [1:0] a);
    case (w)
      WIDTH_B: byte_enable = 4'b0001 << a;
      WIDTH_H: byte_enable = 4'b0011 << a;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input width_e w, input logic [1:0] a);
    case (w)
      WIDTH_B: misaligned = 1'b0;
      WIDTH_H: misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input width_e w, input logic [XLEN-1:0] d);
    case (w)
      WIDTH_B: store_lanes = {4{d[7:0]}};
      WIDTH_H: store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mem_access_if.sv
// Data-RAM port and memory-mapped IO req/ack bus seen by the memory-access stage.
interface rv32i_mem_access_if;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_we;
  logic        io_req;
  logic        io_ack;
  logic [31:0] io_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_be, ram_we,
    output io_addr, io_wdata, io_be, io_we, io_req,
    input  ram_rdata, io_ack, io_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_be, ram_we,
    input  io_addr, io_wdata, io_be, io_we, io_req,
    output ram_rdata, io_ack, io_rdata
  );
endinterface

// File: rtl/rv32i_load_align.sv
// Load lane select plus sign/zero extension, shared by the RAM and IO return paths.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  ld_info_t        info,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (info.lane)
      2'd0:    lane_b = data[7:0];
      2'd1:    lane_b = data[15:8];
      2'd2:    lane_b = data[23:16];
      default: lane_b = data[31:24];
    endcase
    lane_h = info.lane[1] ? data[31:16] : data[15:0];
    case (info.width)
      WIDTH_B: result_c = {{24{lane_b[7] & ~info.is_unsigned}}, lane_b};
      WIDTH_H: result_c = {{16{lane_h[15] & ~info.is_unsigned}}, lane_h};
      default: result_c = data;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_access.sv
// rv32i memory-access stage: RAM port, IO req/ack bus, load alignment and upstream stall.
// Optional IO abort watchdog (io_timeout_out) under RV32I_IO_TIMEOUT_EN.
module rv32i_mem_access
  import rv32i_pkg::*;
#(
  parameter int unsigned IO_TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_reg_in,
  input  logic [1:0]  width_in,
  input  logic        io_en_in,
  input  logic        mem_en_in,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  output logic        io_we,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic        wb_en_out,
  output logic [4:0]  wb_reg_out,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic        misalign_out,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
`ifdef RV32I_IO_TIMEOUT_EN
  output logic        io_timeout_out,
`endif
  output logic [31:0] df_mem_data
);

  state_e      state, state_next;
  width_e      acc_width;
  logic        is_load, is_store, mem_op, use_io, use_ram, bad_align;
  logic [3:0]  be;
  logic [31:0] st_data;
  ld_info_t    ld_info;
  logic [31:0] align_src, align_c;
  logic        retire, io_start, io_done, misalign_next, wb_en_next;
  logic [31:0] wb_data_next;
`ifdef RV32I_IO_TIMEOUT_EN
  logic [7:0]  io_cnt;
  logic        timeout_next;
`endif

  // Decode; IO space takes priority when both selects are set.
  assign acc_width = width_e'(width_in);
  assign is_load   = (iw_in[6:0] == OPC_LOAD);
  assign is_store  = (iw_in[6:0] == OPC_STORE);
  assign mem_op    = is_load | is_store;
  assign use_io    = mem_op & io_en_in;
  assign use_ram   = mem_op & mem_en_in & ~io_en_in;
  assign bad_align = (use_io | use_ram) & misaligned(acc_width, alu_in[1:0]);
  assign be        = byte_enable(acc_width, alu_in[1:0]);
  assign st_data   = store_lanes(acc_width, rs2_data_in);

  assign ram_addr  = {2'b00, alu_in[31:2]};
  assign ram_be    = be;
  assign ram_wdata = st_data;

  assign align_src = (state == ST_RD_WAIT) ? ram_rdata : io_rdata;

  rv32i_load_align u_align (
    .data     (align_src),
    .info     (ld_info),
    .result_c (align_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    stall_out     = 1'b0;
    ram_we        = 1'b0;
    retire        = 1'b0;
    io_start      = 1'b0;
    io_done       = 1'b0;
    misalign_next = 1'b0;
    wb_en_next    = wb_en_in & ~is_store;
    wb_data_next  = alu_in;
`ifdef RV32I_IO_TIMEOUT_EN
    timeout_next  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bad_align) begin
          retire        = 1'b1;
          wb_en_next    = 1'b0;
          misalign_next = 1'b1;
        end else if (use_io) begin
          io_start   = 1'b1;
          stall_out  = 1'b1;
          state_next = ST_IO_WAIT;
        end else if (use_ram && is_load) begin
          stall_out  = 1'b1;
          state_next = ST_RD_WAIT;
        end else begin
          retire = 1'b1;
          ram_we = use_ram & is_store;
        end
      end
      ST_RD_WAIT: begin
        retire       = 1'b1;
        wb_data_next = align_c;
        state_next   = ST_IDLE;
      end
      ST_IO_WAIT: begin
        stall_out = 1'b1;
        if (io_ack) begin
          stall_out  = 1'b0;
          retire     = 1'b1;
          io_done    = 1'b1;
          state_next = ST_IDLE;
          if (is_load) wb_data_next = align_c;
        end
`ifdef RV32I_IO_TIMEOUT_EN
        else if (io_cnt == 8'(IO_TIMEOUT_CYCLES - 1)) begin
          stall_out    = 1'b0;
          retire       = 1'b1;
          io_done      = 1'b1;
          state_next   = ST_IDLE;
          wb_data_next = '1;
          wb_en_next   = 1'b0;
          timeout_next = 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) begin
      stall_out = 1'b0;
      ram_we    = 1'b0;
    end
  end

  // Registered writeback fields hold during stalls; writeback is suppressed until retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_out  <= '0;
      wb_en_out    <= 1'b0;
      wb_reg_out   <= '0;
      iw_out       <= '0;
      pc_out       <= '0;
      misalign_out <= 1'b0;
      ld_info      <= '0;
      io_addr      <= '0;
      io_wdata     <= '0;
      io_be        <= '0;
      io_we        <= 1'b0;
      io_req       <= 1'b0;
    end else begin
      misalign_out <= misalign_next;
      if (retire) begin
        wb_data_out <= wb_data_next;
        wb_en_out   <= wb_en_next;
        wb_reg_out  <= wb_reg_in;
        iw_out      <= iw_in;
        pc_out      <= pc_in;
      end else begin
        wb_en_out <= 1'b0;
      end
      if (state == ST_IDLE) begin
        ld_info <= '{lane: alu_in[1:0], width: acc_width, is_unsigned: iw_in[14]};
      end
      if (io_start) begin
        io_addr  <= alu_in;
        io_wdata <= st_data;
        io_be    <= be;
        io_we    <= is_store;
        io_req   <= 1'b1;
      end else if (io_done) begin
        io_we  <= 1'b0;
        io_req <= 1'b0;
      end
    end
  end

`ifdef RV32I_IO_TIMEOUT_EN
  // Watchdog counts IO_WAIT cycles from zero on every new request.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_cnt         <= '0;
      io_timeout_out <= 1'b0;
    end else begin
      io_timeout_out <= timeout_next;
      io_cnt         <= (state == ST_IO_WAIT) ? io_cnt + 8'd1 : 8'd0;
    end
  end
`endif

  assign df_mem_enable = wb_en_out;
  assign df_mem_reg    = wb_reg_out;
  assign df_mem_data   = wb_data_out;

endmodule

// File: doc/rv32i_mem_access.md
Name: rv32i_mem_access

Overview:
- Memory-access pipeline stage. It sits between the execute stage and writeback.
- It consumes the execute stage's address (alu result), store data, width, and io/mem select.
- It drives the dual-port data RAM port, or the memory-mapped IO bus through a req/ack handshake.
- It returns aligned, sign/zero-extended load data toward writeback, forwards writeback info to decode, and stalls upstream while a RAM read or IO transaction is outstanding.

Parameters:
- IO_TIMEOUT_CYCLES, 16: IO_WAIT cycles tolerated before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alu_in  in  32  effective address or ALU result from execute
- rs2_data_in  in  32  store data
- iw_in  in  32  instruction word
- pc_in  in  32  program counter
- wb_en_in  in  1  writeback enable
- wb_reg_in  in  5  writeback register
- width_in  in  2  access width: 0 byte, 1 half, 2 word
- io_en_in  in  1  IO-space access
- mem_en_in  in  1  RAM-space access
- ram_addr  out  32  word address (alu_in[31:2])
- ram_wdata  out  32  lane-replicated store data
- ram_be  out  4  byte-lane enables
- ram_we  out  1  RAM write strobe
- ram_rdata  in  32  RAM read data, valid one cycle after address
- io_addr  out  32  IO address
- io_wdata  out  32  IO store data
- io_be  out  4  IO byte enables
- io_we  out  1  IO write
- io_req  out  1  IO request
- io_ack  in  1  IO responder ack
- io_rdata  in  32  IO read data, valid with io_ack
- stall_out  out  1  hold the upstream pipeline registers
- wb_data_out  out  32  writeback data
- wb_en_out  out  1  registered writeback enable
- wb_reg_out  out  5  registered writeback register
- iw_out  out  32  registered instruction word
- pc_out  out  32  registered program counter
- misalign_out  out  1  pulses when an access is dropped as misaligned
- df_mem_enable  out  1  forwarding: wb_en_out
- df_mem_reg  out  5  forwarding: wb_reg_out
- df_mem_data  out  32  forwarding: wb_data_out

Behaviour:
- Reset: all registered outputs are 0, io_req/ram_we/io_we/stall_out are 0, FSM goes to IDLE. A reset mid-IO drops io_req in the same cycle it is sampled; a late io_ack is ignored.
- Decode: load = iw_in[6:0]==0000011; store = iw_in[6:0]==0100011; unsigned load = iw_in[14]. RAM is used when mem_en_in=1, IO when io_en_in=1; if both are set, IO wins.
- Byte enables:
  - byte: 0001 << a[1:0]
  - half: 0011 << a[1:0]
  - word: 1111
- Store data: byte replicated ×4, half replicated ×2.
- Misaligned access: half with a[0]=1, or word with a[1:0]!=0.
  - No RAM or IO strobe is issued.
  - misalign_out=1 for one cycle.
  - wb_en_out=0.
  - Instruction completes in IDLE.
- FSM IDLE:
  - Non-memory op: outputs register in 1 cycle; wb_data_out=alu_in.
  - RAM store: ram_we=1 with ram_be combinational this cycle; completes in 1 cycle.
  - RAM load: address issued; go to RD_WAIT with stall_out=1, combinational in this cycle.
  - IO op: latch address, data, be, and we; go to IO_WAIT.
- FSM RD_WAIT:
  - Select ram_rdata lane by latched a[1:0] and width.
  - Sign- or zero-extend; register wb_data_out and the pass-through fields.
  - stall_out=0; return to IDLE.
  - Load latency is 2 cycles.
- FSM IO_WAIT:
  - io_req=1 and latched io_* held stable, stall_out=1.
  - On io_ack: loads take io_rdata with the same lane/extend rules; stores ignore data.
  - Then register outputs, deassert io_req the next cycle, return to IDLE.
  - io_ack in the same cycle as the request's first assertion is legal (2-cycle IO minimum).
- Pass-through: during stall, inputs are held by upstream and registered outputs keep their prior values. wb_en_out is 0 while stalled, so no double writeback occurs.
- Stores always force wb_en_out=0.

Optional Feature:
- Macro: RV32I_IO_TIMEOUT_EN.
- Defined: an 8-bit counter runs in IO_WAIT. When it reaches IO_TIMEOUT_CYCLES without io_ack:
  - io_req drops;
  - load data = 32'hFFFF_FFFF, wb_en_out=0;
  - io_timeout_out (extra 1-bit output) pulses;
  - FSM returns to IDLE.
- Undefined: no counter and no port; IO_WAIT waits indefinitely.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants OPC_LOAD and OPC_STORE;
  - width enum WIDTH_B/H/W;
  - FSM state enum;
  - function for byte-enable generation.
- One sub-module, rv32i_load_align: combinational lane select plus sign/zero extension, shared by the RAM and IO paths.

Test Plan:
- SW at a=0x100, rs2=0xDEADBEEF -> same cycle ram_we=1, ram_be=1111, ram_wdata=0xDEADBEEF, wb_en_out=0.
- SB a=0x103, rs2=0x000000A5 -> ram_be=1000, ram_wdata=0xA5A5A5A5.
- LB a=0x102 with ram_rdata=0x1280_3456 -> stall_out is 1 for one cycle, wb_data_out=0xFFFFFF80. LBU on the same data -> 0x00000080.
- LH a=0x101 -> misalign_out pulse, no ram_we/io_req, wb_en_out=0, no stall.
- IO LW a=0x8000_0010, io_ack after 3 cycles with io_rdata=0x55 -> stall for 3 cycles, io_req stable, wb_data_out=0x55. Reset asserted mid-wait drops io_req next edge.
- With RV32I_IO_TIMEOUT_EN and IO_TIMEOUT_CYCLES=4, no io_ack -> io_timeout_out pulses after 4 wait cycles, wb_en_out=0, FSM returns to IDLE.
